// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pre-add / multiply / post-add DSP slice.
//   p = b * (a -/+ d) + {0 | c | pci | p}
// The pipeline has four register stages: S1 inputs, S2 pre-adder, S3 multiplier, S4 post-adder and p.
// Each sample's control (opmode, acc_clr) and its c operand move down the pipe with the sample.
// pci is not registered. It is sampled in S4, so p of one slice can feed pci of the next slice.
// Optional build macro DSP_MAC_SAT_EN: when defined, the post-adder saturates and drives ovf.
// When the macro is undefined, the post-adder wraps and ovf is tied to 0.
//
// Handshake: in_valid marks a sample on the inputs in that cycle. There is no ready signal and no stall.
// out_valid pulses for one cycle each time p takes a new result. On a bubble, p and ovf hold.

module dsp_mac_pipe #(
    parameter int DW      = 8,
    parameter int BW      = 18,
    parameter int PW      = 32,
    parameter int PRE_SUB = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic [BW-1:0] b,
    input  logic [PW-1:0] c,
    input  logic [PW-1:0] pci,
    input  logic [1:0]    opmode,
    input  logic          acc_clr,
    output logic          out_valid,
    output logic [PW-1:0] p,
    output logic          ovf
);

    localparam int PREW = DW + 2;       // pre-adder result width
    localparam int MW   = BW + DW + 2;  // exact product width

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_C    = 2'b01;
    localparam logic [1:0] OP_PCI  = 2'b10;
    localparam logic [1:0] OP_ACC  = 2'b11;

    // ---------------- S1: input registers ----------------
    logic signed [DW:0]   a1, d1;
    logic signed [BW-1:0] b1;
    logic signed [PW-1:0] c1;
    logic [1:0]           op1;
    logic                 clr1, v1;

    // S1 registers the inputs. a and d are zero-extended because they are unsigned samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1   <= '0;
            d1   <= '0;
            b1   <= '0;
            c1   <= '0;
            op1  <= '0;
            clr1 <= 1'b0;
            v1   <= 1'b0;
        end else begin
            a1   <= $signed({1'b0, a});
            d1   <= $signed({1'b0, d});
            b1   <= $signed(b);
            c1   <= $signed(c);
            op1  <= opmode;
            clr1 <= acc_clr;
            v1   <= in_valid;
        end
    end

    // ---------------- S2: pre-adder ----------------
    logic signed [PREW-1:0] pre_nxt;
    logic signed [PREW-1:0] pre2;
    logic signed [BW-1:0]   b2;
    logic signed [PW-1:0]   c2;
    logic [1:0]             op2;
    logic                   clr2, v2;

    // The pre-adder is one bit wider than its operands, so a - d and a + d never overflow.
    always_comb begin
        pre_nxt = '0;
        if (PRE_SUB != 0) begin
            pre_nxt = PREW'(a1) - PREW'(d1);
        end else begin
            pre_nxt = PREW'(a1) + PREW'(d1);
        end
    end

    // S2 registers the pre-adder result and moves the coefficient and control on by one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre2 <= '0;
            b2   <= '0;
            c2   <= '0;
            op2  <= '0;
            clr2 <= 1'b0;
            v2   <= 1'b0;
        end else begin
            pre2 <= pre_nxt;
            b2   <= b1;
            c2   <= c1;
            op2  <= op1;
            clr2 <= clr1;
            v2   <= v1;
        end
    end

    // ---------------- S3: multiplier ----------------
    logic signed [MW-1:0] m3;
    logic signed [PW-1:0] c3;
    logic [1:0]           op3;
    logic                 clr3, v3;

    // S3 registers the exact signed product b * pre. MW bits cannot overflow for any operand values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m3   <= '0;
            c3   <= '0;
            op3  <= '0;
            clr3 <= 1'b0;
            v3   <= 1'b0;
        end else begin
            m3   <= MW'(b2) * MW'(pre2);
            c3   <= c2;
            op3  <= op2;
            clr3 <= clr2;
            v3   <= v2;
        end
    end

    // ---------------- S4: post-adder ----------------
    logic signed [PW-1:0] m_ext;
    logic signed [PW-1:0] src;

    // Select the post-adder source for the sample now in S4.
    // In accumulate mode, acc_clr starts a new sum from zero.
    always_comb begin
        m_ext = PW'(m3);
        src   = '0;
        case (op3)
            OP_NONE: src = '0;
            OP_C:    src = c3;
            OP_PCI:  src = $signed(pci);
            OP_ACC:  src = clr3 ? '0 : $signed(p);
            default: src = '0;
        endcase
    end

`ifdef DSP_MAC_SAT_EN
    localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

    logic signed [PW:0]   sum;
    logic                 sum_ovf;
    logic signed [PW-1:0] sum_sat;

    // The sum is computed one bit wider than p. When its top two bits differ, the result is clamped.
    always_comb begin
        sum     = (PW+1)'(m_ext) + (PW+1)'(src);
        sum_ovf = (sum[PW] != sum[PW-1]);
        sum_sat = sum[PW-1:0];
        if (sum_ovf) begin
            sum_sat = sum[PW] ? P_MIN : P_MAX;
        end
    end

    // p, ovf and out_valid update only for valid samples. A bubble leaves the accumulator unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                p   <= sum_sat;
                ovf <= sum_ovf;
            end
        end
    end
`else
    logic signed [PW-1:0] sum;

    // Without saturation, only the low PW bits of the sum are kept, so the result wraps.
    always_comb begin
        sum = m_ext + src;
    end

    // p and out_valid update only for valid samples. A bubble leaves the accumulator unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                p <= sum;
            end
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Testbench for dsp_mac_pipe, using directed vectors with expected values worked out by hand.
// u_dut is the default slice (PRE_SUB=1).
// u_add uses PRE_SUB=0, and its pci input is connected to u_dut.p to form a cascade.
module tb_dsp_mac_pipe;

  logic clk;
  logic rst_n;

  // Instance 0 (default, pre-subtract)
  logic               iv0, clr0;
  logic [7:0]         a0, d0;
  logic [17:0]        b0;
  logic [31:0]        c0, pci0;
  logic [1:0]         op0;
  logic               ov0, ovf0;
  logic signed [31:0] p0;

  // Instance 1 (pre-add, pci <- p0)
  logic               iv1, clr1;
  logic [7:0]         a1, d1;
  logic [17:0]        b1;
  logic [31:0]        c1;
  logic [1:0]         op1;
  logic               ov1, ovf1;
  logic signed [31:0] p1;

  int checks;
  int errors;

  dsp_mac_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .a(a0), .d(d0), .b(b0), .c(c0),
    .pci(pci0), .opmode(op0), .acc_clr(clr0), .out_valid(ov0), .p(p0), .ovf(ovf0)
  );

  dsp_mac_pipe #(.PRE_SUB(0)) u_add (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .d(d1), .b(b1), .c(c1),
    .pci(p0), .opmode(op1), .acc_clr(clr1), .out_valid(ov1), .p(p1), .ovf(ovf1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    iv0 = 0; clr0 = 0; a0 = 0; d0 = 0; b0 = 0; c0 = 0; pci0 = 0; op0 = 0;
    iv1 = 0; clr1 = 0; a1 = 0; d1 = 0; b1 = 0; c1 = 0; op1 = 0;
    repeat (3) @(negedge clk);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov0); end
    checks++; if (p0 !== 32'sd0) begin errors++; $display("FAIL reset_p got %0d exp 0", p0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    @(negedge clk);
    iv0 = 1; a0 = 200; d0 = 50; b0 = 18'd3; c0 = 0; op0 = 2'b00; clr0 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      iv0 = 0;
      checks++;
      if (ov0 !== logic'(k == 4)) begin
        errors++; $display("FAIL latency_valid k=%0d got %b exp %b", k, ov0, (k == 4));
      end
      if (k == 4) begin
        checks++; if (p0 !== 32'sd450) begin errors++; $display("FAIL latency_p got %0d exp 450", p0); end
      end
    end
  endtask

  task automatic test_post_c;
    @(negedge clk);
    iv0 = 1; a0 = 10; d0 = 20; b0 = 18'(-5); c0 = 32'd1000; op0 = 2'b01; clr0 = 0;
    iv1 = 1; a1 = 10; d1 = 20; b1 = 18'(-5); c1 = 32'd1000; op1 = 2'b01; clr1 = 0;
    @(negedge clk);
    iv0 = 0; iv1 = 0;
    repeat (3) @(negedge clk);
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL post_c_valid got %b exp 1", ov0); end
    checks++; if (p0 !== 32'sd1050) begin errors++; $display("FAIL post_c_sub_p got %0d exp 1050", p0); end
    checks++; if (p1 !== 32'sd850) begin errors++; $display("FAIL post_c_add_p got %0d exp 850", p1); end
  endtask

  // pat bit k = in_valid in cycle k; first valid sample carries acc_clr
  task automatic test_accumulate(input logic [15:0] pat, input string name);
    int  acc;
    bit  started;
    bit  clr_pending;
    acc = 0; started = 0; clr_pending = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        checks++;
        if (ov0 !== pat[k-4]) begin
          errors++; $display("FAIL %s_valid k=%0d got %b exp %b", name, k, ov0, pat[k-4]);
        end
        if (pat[k-4]) begin
          acc = started ? acc + 100 : 100;
          started = 1;
        end
        if (started) begin
          checks++;
          if (p0 !== acc) begin errors++; $display("FAIL %s_p k=%0d got %0d exp %0d", name, k, p0, acc); end
        end
      end
      iv0 = (k < 16) ? pat[k] : 1'b0;
      clr0 = iv0 && clr_pending;
      if (iv0) clr_pending = 0;
      a0 = 60; d0 = 10; b0 = 18'd2; c0 = 0; op0 = 2'b11;
    end
    checks++; if (p0 !== 32'sd400) begin errors++; $display("FAIL %s_final got %0d exp 400", name, p0); end
    clr0 = 0;
  endtask

  task automatic test_cascade;
    bit seen;
    seen = 0;
    @(negedge clk);
    iv0 = 1; a0 = 5; d0 = 1; b0 = 18'd10; c0 = 0; op0 = 2'b00; clr0 = 0;
    @(negedge clk);
    iv0 = 0;
    iv1 = 1; a1 = 3; d1 = 0; b1 = 18'd7; c1 = 0; op1 = 2'b10; clr1 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      iv1 = 0;
      if (ov1 && !seen) begin
        seen = 1;
        checks++; if (k != 4) begin errors++; $display("FAIL cascade_latency got %0d exp 4", k); end
        checks++; if (p1 !== 32'sd61) begin errors++; $display("FAIL cascade_p got %0d exp 61", p1); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL cascade_timeout got no out_valid exp one"); end
    checks++; if (p0 !== 32'sd40) begin errors++; $display("FAIL cascade_a_p got %0d exp 40", p0); end
  endtask

  task automatic test_saturation;
    logic signed [31:0] exp65;
    logic               expovf;
`ifdef DSP_MAC_SAT_EN
    exp65 = 32'sd2147483647; expovf = 1'b1;
`else
    exp65 = -32'sd2122465471; expovf = 1'b0;
`endif
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk);
      if (k - 3 == 64) begin
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL sat64_valid got %b exp 1", ov0); end
        checks++; if (p0 !== 32'sd2139078720) begin errors++; $display("FAIL sat64_p got %0d exp 2139078720", p0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL sat64_ovf got %b exp 0", ovf0); end
      end
      if (k - 3 == 65) begin
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL sat65_valid got %b exp 1", ov0); end
        checks++; if (p0 !== exp65) begin errors++; $display("FAIL sat65_p got %0d exp %0d", p0, exp65); end
        checks++; if (ovf0 !== expovf) begin errors++; $display("FAIL sat65_ovf got %b exp %b", ovf0, expovf); end
      end
      iv0 = (k < 65); clr0 = (k == 0);
      a0 = 255; d0 = 0; b0 = 18'd131071; c0 = 0; op0 = 2'b11;
    end
    clr0 = 0;
  endtask

  task automatic test_reset_midstream;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        checks++; if (p0 !== 32'sd4) begin errors++; $display("FAIL midrst_pre_p got %0d exp 4", p0); end
      end
      iv0 = 1; a0 = 8'(k + 1); d0 = 0; b0 = 18'd1; c0 = 0; op0 = 2'b00; clr0 = 0;
    end
    #2;
    rst_n = 1'b0;
    iv0 = 0;
    #1;
    checks++; if (p0 !== 32'sd0) begin errors++; $display("FAIL midrst_p got %0d exp 0", p0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", ov0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", ovf0); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b0 || p0 !== 32'sd0) begin
        errors++; $display("FAIL midrst_after k=%0d got valid=%b p=%0d exp valid=0 p=0", k, ov0, p0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_post_c();
    test_accumulate(16'h000F, "acc_b2b");
    test_accumulate(16'h0063, "acc_gap");
    test_cascade();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
